// File: rtl/la_pkg.sv
// Shared definitions for the linear-algebra datapath blocks: default sizes,
// width helpers and the load/multiply/output state encoding.
package la_pkg;

  localparam int N_DEF = 5;
  localparam int W_DEF = 8;

  // Exact product width: W x W product plus log2(N) bits of accumulation growth.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF  = idx_width(N_DEF);
  localparam int LOAD_W_DEF = idx_width(2 * N_DEF * N_DEF);
  localparam int ACCW_DEF   = acc_width(N_DEF, W_DEF);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_mac.sv
// Registered signed W x W multiply-accumulate. clear has priority over en;
// with en low the accumulator holds its value.
module matrix_mac #(
  parameter int W    = 8,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   en,
  input  logic signed [W-1:0]    a,
  input  logic signed [W-1:0]    b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      // Size cast of a signed value sign-extends the product to ACCW.
      acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/matrix_multiply_check.sv
// Streaming N x N signed matrix multiplier P = A*B with an identity check,
// used to self-check the output of the matrix-inverse engine.
module matrix_multiply_check
  import la_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int ACCW = acc_width(N, W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   out_last,
  output logic                   out_ident
);

  localparam int NN = N * N;
  localparam int IW = idx_width(N);
  localparam int AW = idx_width(NN);
  localparam int LW = idx_width(2 * NN);

  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [LW-1:0] LAST_LOAD = LW'(2 * NN - 1);
  localparam logic [LW-1:0] B_BASE    = LW'(NN);

  state_t          state_reg;
  logic [LW-1:0]   ld_cnt_reg;
  logic [IW-1:0]   r_reg;
  logic [IW-1:0]   c_reg;
  logic [IW-1:0]   k_reg;
  logic            ident_ok_reg;

  logic signed [W-1:0] a_mem [NN];
  logic signed [W-1:0] b_mem [NN];

  logic                   load_hs;
  logic                   load_done;
  logic                   out_hs;
  logic                   last_term;
  logic                   wr_b;
  logic [AW-1:0]          wr_idx;
  logic [AW-1:0]          a_idx;
  logic [AW-1:0]          b_idx;
  logic signed [W-1:0]    a_op;
  logic signed [W-1:0]    b_op;
  logic                   mac_clear;
  logic                   mac_en;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] ident_val;
  logic                   cur_match;

  assign in_ready  = (state_reg == LOAD);
  assign out_valid = (state_reg == OUT);

  assign load_hs   = in_valid && in_ready;
  assign load_done = load_hs && (ld_cnt_reg == LAST_LOAD);
  assign out_hs    = out_valid && out_ready;
  assign last_term = (k_reg == LAST_IDX);

  // First N*N elements fill A, the next N*N fill B, both row-major.
  assign wr_b   = (ld_cnt_reg >= B_BASE);
  assign wr_idx = wr_b ? AW'(ld_cnt_reg - B_BASE) : AW'(ld_cnt_reg);

  always_ff @(posedge clk) begin
    if (load_hs) begin
      if (wr_b) begin
        b_mem[wr_idx] <= in_data;
      end else begin
        a_mem[wr_idx] <= in_data;
      end
    end
  end

  assign a_idx = AW'(int'(r_reg) * N + int'(k_reg));
  assign b_idx = AW'(int'(k_reg) * N + int'(c_reg));
  assign a_op  = a_mem[a_idx];
  assign b_op  = b_mem[b_idx];

  // Accumulator restarts whenever a new dot product is about to begin.
  assign mac_clear = load_done || (out_hs && !out_last);
  assign mac_en    = (state_reg == MAC);

  matrix_mac #(
    .W    (W),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (a_op),
    .b     (b_op),
    .acc   (acc)
  );

  assign out_data  = acc;
  assign out_last  = out_valid && (r_reg == LAST_IDX) && (c_reg == LAST_IDX);
  assign ident_val = (r_reg == c_reg) ? ACCW'(1) : '0;
  assign cur_match = (acc == ident_val);
  // The element on the bus counts toward the verdict before its handshake.
  assign out_ident = out_last && ident_ok_reg && cur_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      ld_cnt_reg   <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      k_reg        <= '0;
      ident_ok_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (load_hs) begin
            if (load_done) begin
              ld_cnt_reg   <= '0;
              r_reg        <= '0;
              c_reg        <= '0;
              k_reg        <= '0;
              ident_ok_reg <= 1'b1;
              state_reg    <= MAC;
            end else begin
              ld_cnt_reg <= ld_cnt_reg + 1'b1;
            end
          end
        end
        MAC: begin
          if (last_term) begin
            k_reg     <= '0;
            state_reg <= OUT;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            ident_ok_reg <= ident_ok_reg && cur_match;
            if (out_last) begin
              ld_cnt_reg <= '0;
              state_reg  <= LOAD;
            end else begin
              if (c_reg == LAST_IDX) begin
                c_reg <= '0;
                r_reg <= r_reg + 1'b1;
              end else begin
                c_reg <= c_reg + 1'b1;
              end
              k_reg     <= '0;
              state_reg <= MAC;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiply_check.sv
// Scoreboard bench for matrix_multiply_check: directed matrix pairs with
// hand-derived products, backpressure, load gaps and mid-stream resets.
module tb_matrix_multiply_check;
  import la_pkg::*;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int ACCW = 19;
  localparam int NN   = N * N;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [W-1:0]    in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [ACCW-1:0] out_data;
  logic                   out_last;
  logic                   out_ident;

  always #5 clk = ~clk;

  matrix_multiply_check #(
    .N    (N),
    .W    (W),
    .ACCW (ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ident (out_ident)
  );

  typedef struct {
    logic signed [ACCW-1:0] data;
    logic                   last;
    logic                   ident;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  bit cad_en = 1'b0;

  logic signed [W-1:0]    a_m   [NN];
  logic signed [W-1:0]    b_m   [NN];
  logic signed [ACCW-1:0] exp_m [NN];
  logic                   exp_ident;

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out got data=%0d want no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        tests++;
        if (out_data !== mon_e.data || out_last !== mon_e.last ||
            (mon_e.last && out_ident !== mon_e.ident)) begin
          fails++;
          $display("FAIL out_elem #%0d got data=%0d last=%0b ident=%0b want data=%0d last=%0b ident=%0b",
                   out_cnt, out_data, out_last, out_ident, mon_e.data, mon_e.last, mon_e.ident);
        end else begin
          $display("[TB] out #%0d data=%0d last=%0b ident=%0b ok", out_cnt, out_data, out_last, out_ident);
        end
        if (cad_en && out_cnt > 0) begin
          tests++;
          if (cyc - last_hs_cyc != N + 1) begin
            fails++;
            $display("FAIL out_cadence got %0d cycles want %0d", cyc - last_hs_cyc, N + 1);
          end
        end
      end
      last_hs_cyc = cyc;
      out_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  // Streams lim elements (A then B); gaps inserts idle cycles on in_valid.
  task automatic load_pair(input int lim, input bit gaps);
    int  sent = 0;
    int  guard = 0;
    bit  hs;
    while (sent < lim && guard < 2000) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'sh55;
      end else begin
        in_valid = 1'b1;
        in_data  = (sent < NN) ? a_m[sent] : b_m[sent - NN];
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) sent++;
      guard++;
    end
    in_valid = 1'b0;
    if (sent < lim) begin
      tests++;
      fails++;
      $display("FAIL load_timeout got %0d elements want %0d", sent, lim);
    end
  endtask

  task automatic run_pair(input bit gaps, input bit chk_lat);
    exp_t e;
    int   n;
    for (int i = 0; i < NN; i++) begin
      e.data  = exp_m[i];
      e.last  = (i == NN - 1);
      e.ident = exp_ident;
      sb.push_back(e);
    end
    out_cnt = 0;
    load_pair(2 * NN, gaps);
    if (chk_lat) begin
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        n++;
        if (out_valid) break;
      end
      check("first_out_latency", n, N + 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    check("in_ready_after_last", in_ready, 1);
    check("out_valid_after_last", out_valid, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_a_ident();
    for (int i = 0; i < NN; i++) a_m[i] = (i / N == i % N) ? 8'sd1 : 8'sd0;
  endtask

  task automatic set_b_ident();
    for (int i = 0; i < NN; i++) b_m[i] = (i / N == i % N) ? 8'sd1 : 8'sd0;
  endtask

  task automatic set_uniform(input int av, input int bv, input int pv);
    for (int i = 0; i < NN; i++) begin
      a_m[i]   = W'(av);
      b_m[i]   = W'(bv);
      exp_m[i] = ACCW'(pv);
    end
    exp_ident = 1'b0;
  endtask

  initial begin
    int n;
    logic signed [ACCW-1:0] d0;
    logic                   l0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_ident", out_ident, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // A = I, B = I: identity product with steady one-per-(N+1) cadence.
    set_a_ident();
    set_b_ident();
    for (int i = 0; i < NN; i++) exp_m[i] = (i / N == i % N) ? 19'sd1 : 19'sd0;
    exp_ident = 1'b1;
    cad_en = 1'b1;
    run_pair(1'b0, 1'b1);
    drain();
    check("ident_handshakes", out_cnt, NN);
    cad_en = 1'b0;

    // A = I, B = ramp: product is the ramp.
    set_a_ident();
    for (int i = 0; i < NN; i++) begin
      b_m[i]   = W'(i);
      exp_m[i] = ACCW'(i);
    end
    exp_ident = 1'b0;
    run_pair(1'b0, 1'b0);
    drain();

    // A = ramp, B = I: product is the ramp via the A operand path.
    set_b_ident();
    for (int i = 0; i < NN; i++) a_m[i] = W'(i);
    run_pair(1'b0, 1'b0);
    drain();

    set_uniform(127, 127, 80645);
    run_pair(1'b0, 1'b0);
    drain();
    set_uniform(-128, -128, 81920);
    run_pair(1'b0, 1'b0);
    drain();
    set_uniform(-128, 127, -81280);
    run_pair(1'b0, 1'b0);
    drain();

    // Backpressure: stall while element 3 is presented.
    set_a_ident();
    for (int i = 0; i < NN; i++) b_m[i] = W'(i);
    for (int i = 0; i < NN; i++) exp_m[i] = ACCW'(i);
    exp_ident = 1'b0;
    run_pair(1'b0, 1'b0);
    n = 0;
    while (out_cnt < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    d0 = out_data;
    l0 = out_last;
    check("stall_elem3_data", d0, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0) begin
        fails++;
        $display("FAIL stall_hold got valid=%0b data=%0d last=%0b want valid=1 data=%0d last=%0b",
                 out_valid, out_data, out_last, d0, l0);
      end else begin
        $display("[TB] stall cycle %0d data=%0d held ok", i, out_data);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("stall_handshakes", out_cnt, NN);

    // in_valid gaps during load: same ramp products, same latency.
    for (int i = 0; i < NN; i++) a_m[i] = W'(i);
    set_b_ident();
    run_pair(1'b1, 1'b1);
    drain();

    // Reset after 20 load handshakes, then a fresh identity pair.
    load_pair(20, 1'b0);
    pulse_reset();
    set_a_ident();
    set_b_ident();
    for (int i = 0; i < NN; i++) exp_m[i] = (i / N == i % N) ? 19'sd1 : 19'sd0;
    exp_ident = 1'b1;
    run_pair(1'b0, 1'b1);
    drain();

    // Reset in the middle of the output phase, then a uniform pair.
    for (int i = 0; i < NN; i++) begin
      b_m[i]   = W'(i);
      exp_m[i] = ACCW'(i);
    end
    exp_ident = 1'b0;
    run_pair(1'b0, 1'b0);
    n = 0;
    while (out_cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    pulse_reset();
    set_uniform(-128, 127, -81280);
    run_pair(1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_multiply_check.md
# matrix_multiply_check

Streaming N×N signed matrix multiplier that computes P = A·B and flags whether P is exactly the identity. It sits downstream of the matrix-inverse engine in the linear-algebra datapath. It consumes a source matrix A and a candidate inverse B over a valid/ready element stream, then returns the product elements on a second valid/ready stream. The identity flag gives hardware self-check of inversion results.

## Interface

Parameters:
- N, 5, matrix dimension (rows = columns)
- W, 8, element width, signed two's complement
- ACCW, 2*W+$clog2(N), product/accumulator width (19 at defaults)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a valid element
- in_ready  output  1  block accepts an element this cycle
- in_data  input  W  element; A row-major, then B row-major
- out_valid  output  1  out_data holds a valid product element
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  ACCW  product element P[r][c], signed
- out_last  output  1  high with P[N-1][N-1]
- out_ident  output  1  valid with out_last; 1 iff every P[r][c] equals identity (diagonal 1, off-diagonal 0)

## Operation

- States: LOAD, MAC, OUT.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) writes the element to A store for counts 0..N²-1 and to B store for counts N²..2N²-1, row-major.
  - Handshake on count 2N²-1 → MAC, with r=c=0, k=0, acc=0, ident_ok=1.
- MAC:
  - in_ready=0.
  - Each cycle: acc += A[r][k]*B[k][c], full signed ACCW arithmetic, no overflow possible. k increments.
  - After the k=N-1 term → OUT, with out_data=final sum.
- OUT:
  - out_valid=1; out_data, out_last and out_ident held stable until handshake.
  - On handshake: ident_ok &= (out_data == (r==c ? 1 : 0)).
    - If r=c=N-1 → LOAD, count=0.
    - Otherwise advance c, wrapping to 0 and incrementing r; acc=0, k=0 → MAC.
  - out_ident is computed combinationally with the current element included.
- in_valid gaps in LOAD stall the count; no element is skipped.
- out_ready held high with no stalls gives steady state of one output per N+1 cycles.
- Reset while in any state:
  - Immediate return to LOAD, all counters zero, in-flight matrices discarded.
  - Stored A/B contents need not be cleared.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, out_ident=0; state LOAD.
- Last load handshake at cycle t: MAC cycles t+1..t+N; out_valid rises at t+N+1.
- Output handshake at cycle u (not last): out_valid=0 for cycles u+1..u+N; next out_valid at u+N+1.
- Last output handshake at cycle u: in_ready=1 at u+1.
- out_valid never depends combinationally on out_ready. in_ready depends only on state.
- Minimum period per matrix pair: 2N² + N²(N+1) cycles (200 at N=5).

## Structure

- Shared package la_pkg: default N and W, ACCW function, state enum (LOAD, MAC, OUT), index width constants.
- One sub-module: matrix_mac, a registered signed W×W multiply with ACCW accumulate. It has clear and enable inputs and holds acc when enable is low.
- Top level holds the A/B register arrays, counters r/c/k/load count, the FSM and ident_ok.

## Test plan

- A=I, B=I (N=5) → 25 outputs; diagonal 1, off-diagonal 0; out_last on the 25th; out_ident=1.
- A=I, B[r][c]=r*5+c → out_data sequence 0..24 row-major; out_ident=0.
- A all 127, B all 127 → every out_data=80645. A all -128, B all -128 → every out_data=81920. A all -128, B all 127 → every out_data=-81280. out_ident=0 in each case.
- Backpressure: out_ready low for 10 cycles while element 3 is presented → out_valid, out_data and out_last stable throughout. No element lost or duplicated; total 25 handshakes.
- in_valid toggled 1-0 pseudo-randomly during load → same products as a gap-free load. First out_valid exactly N+1 cycles after the 50th handshake.
- rst pulsed after 20 load handshakes, and again mid-OUT in a later run → next cycle in_ready=1, out_valid=0. The following 50 elements produce correct products for the new pair.
